axis_length_fill_core: RTL and testbench

//  Fixed-length AXI-Stream packet normaliser: every input packet leaves as exactly
//  `length` beats. Short packets are zero-padded after their last beat; long packets
//  are truncated and their surplus beats are consumed and discarded.

---
 rtl/axis_length_fill_core.sv | 144 ++++++++++++++
 tb/tb_axis_length_fill_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_length_fill_core.sv
// Fixed-length AXI-Stream normaliser: each input packet leaves as exactly `length` beats
// (short packets zero-padded, long packets truncated with surplus beats drained); length==0 passes through.
// Latency: zero in PASS (combinational forwarding); pad beats follow back-to-back under out_tready.
// Backpressure: PASS ties in_tready to out_tready, PAD stalls the input, DROP always accepts; aclken=0 freezes all.
// Ports: aclk/aresetn/aclken, length (sampled on first beat), axis_in_* slave side, axis_out_* master side.
module axis_length_fill_core #(
    parameter int               DSIZE     = 8,
    parameter logic [DSIZE-1:0] PAD_VALUE = '0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             aclken,
    input  logic [31:0]      length,
    input  logic [DSIZE-1:0] axis_in_tdata,
    input  logic             axis_in_tvalid,
    output logic             axis_in_tready,
    input  logic             axis_in_tlast,
    input  logic             axis_in_tuser,
    output logic [DSIZE-1:0] axis_out_tdata,
    output logic             axis_out_tvalid,
    input  logic             axis_out_tready,
    output logic             axis_out_tlast,
    output logic             axis_out_tuser
);

    localparam logic [1:0] ST_PASS = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      len_q, len_d;

    logic             run;
    logic             first_beat;
    logic [31:0]      len_cur;
    logic             at_end;
    logic             in_beat;
    logic             out_beat;
    logic             in_rdy;
    logic             out_vld;
    logic             out_last;
    logic             out_user;
    logic [DSIZE-1:0] out_dat;

    always_comb begin
        run        = aresetn && aclken;
        // The first beat of a packet must already see the new length, so it
        // bypasses len_q; every later beat uses the latched copy.
        first_beat = (state_q == ST_PASS) && (cnt_q == 32'd0);
        len_cur    = first_beat ? length : len_q;
        at_end     = (cnt_q == (len_cur - 32'd1));

        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        in_rdy   = 1'b0;
        out_vld  = 1'b0;
        out_last = 1'b0;
        out_user = 1'b0;
        out_dat  = '0;
        in_beat  = 1'b0;
        out_beat = 1'b0;

        case (state_q)
            ST_PASS: begin
                out_vld  = run && axis_in_tvalid;
                in_rdy   = run && axis_out_tready;
                out_dat  = axis_in_tdata;
                out_user = axis_in_tuser;
                out_last = (len_cur == 32'd0) ? axis_in_tlast : at_end;
                in_beat  = axis_in_tvalid && in_rdy;
                if (in_beat) begin
                    if (first_beat) begin
                        len_d = length;
                    end
                    if (len_cur == 32'd0) begin
                        // Transparent mode: only track packet boundaries.
                        cnt_d = axis_in_tlast ? 32'd0 : cnt_q + 32'd1;
                    end else if (at_end) begin
                        cnt_d   = 32'd0;
                        state_d = axis_in_tlast ? ST_PASS : ST_DROP;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        if (axis_in_tlast) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                out_vld  = run;
                out_dat  = PAD_VALUE;
                out_last = at_end;
                out_beat = out_vld && axis_out_tready;
                if (out_beat) begin
                    if (at_end) begin
                        cnt_d   = 32'd0;
                        state_d = ST_PASS;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            ST_DROP: begin
                in_rdy  = run;
                in_beat = axis_in_tvalid && in_rdy;
                if (in_beat && axis_in_tlast) begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d = ST_PASS;
                cnt_d   = 32'd0;
            end
        endcase

        // While reset is held the bus is quiet regardless of what the source drives.
        if (!aresetn) begin
            out_dat  = '0;
            out_last = 1'b0;
            out_user = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_PASS;
            cnt_q   <= 32'd0;
            len_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign axis_in_tready  = in_rdy;
    assign axis_out_tvalid = out_vld;
    assign axis_out_tdata  = out_dat;
    assign axis_out_tlast  = out_last;
    assign axis_out_tuser  = out_user;

endmodule

// File: tb/tb_axis_length_fill_core.sv
// Bench for axis_length_fill_core: packet-level expectation queue plus literal packet checks.
// Latency: driver and ready generator act 1 time unit after the rising edge; outputs sampled on the falling edge.
// Backpressure: optional random out_tready and random in_tvalid gaps; stalled outputs must hold.
module tb_axis_length_fill_core;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        aclken = 1'b1;
    logic [31:0] length = 32'd5;
    logic [7:0]  axis_in_tdata = '0;
    logic        axis_in_tvalid = 1'b0;
    logic        axis_in_tready;
    logic        axis_in_tlast = 1'b0;
    logic        axis_in_tuser = 1'b0;
    logic [7:0]  axis_out_tdata;
    logic        axis_out_tvalid;
    logic        axis_out_tready = 1'b0;
    logic        axis_out_tlast;
    logic        axis_out_tuser;

    axis_length_fill_core #(.DSIZE(8), .PAD_VALUE(8'h00)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .aclken          (aclken),
        .length          (length),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tready  (axis_in_tready),
        .axis_in_tlast   (axis_in_tlast),
        .axis_in_tuser   (axis_in_tuser),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tuser  (axis_out_tuser)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       pad;
    } beat_t;

    beat_t exp_q[$];
    beat_t out_log[$];
    beat_t e;
    beat_t o;
    int    lit_d[$];
    int    checks = 0;
    int    failures = 0;
    bit    rnd_rdy = 1'b0;
    bit    gap_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected output of one whole packet from the normalisation rule alone:
    // the first min(n,L) input beats, then pad up to L, tlast on beat L.
    function automatic void push_expect(input int n, input int start, input int len);
        int tot;
        tot = (len == 0) ? n : len;
        for (int i = 0; i < tot; i++) begin
            beat_t b;
            if (i < n) begin
                b.d   = 8'(start + i);
                b.u   = b.d[0];
                b.pad = 1'b0;
            end else begin
                b.d   = 8'h00;
                b.u   = 1'b0;
                b.pad = 1'b1;
            end
            b.l = (len == 0) ? (i == n - 1) : (i == len - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Single compare process: every accepted output beat against the model,
    // plus hold-under-stall and no-input-during-pad checks.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;
    logic       prev_u;

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", {31'd0, axis_out_tvalid}, 32'd1);
                chk("stall_dat", {24'd0, axis_out_tdata}, {24'd0, prev_d});
                chk("stall_last", {31'd0, axis_out_tlast}, {31'd0, prev_l});
                chk("stall_user", {31'd0, axis_out_tuser}, {31'd0, prev_u});
            end
            if (axis_out_tvalid && exp_q.size() > 0 && exp_q[0].pad) begin
                chk("in_rdy_during_pad", {31'd0, axis_in_tready}, 32'd0);
            end
            if (axis_out_tvalid && axis_out_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_beat", {24'd0, axis_out_tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_dat", {24'd0, axis_out_tdata}, {24'd0, e.d});
                    chk("out_last", {31'd0, axis_out_tlast}, {31'd0, e.l});
                    chk("out_user", {31'd0, axis_out_tuser}, {31'd0, e.u});
                end
                o.d   = axis_out_tdata;
                o.l   = axis_out_tlast;
                o.u   = axis_out_tuser;
                o.pad = 1'b0;
                out_log.push_back(o);
            end
            prev_stall = axis_out_tvalid && !axis_out_tready;
            prev_d     = axis_out_tdata;
            prev_l     = axis_out_tlast;
            prev_u     = axis_out_tuser;
        end
    end

    always @(posedge aclk) begin
        if (rnd_rdy) begin
            #1;
            axis_out_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_pkt(input int n, input int start);
        logic acc;
        int   cyc;
        push_expect(n, start, int'(length));
        for (int i = 0; i < n; i++) begin
            if (gap_en) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge aclk);
                    #1;
                end
            end
            axis_in_tdata  = 8'(start + i);
            axis_in_tuser  = axis_in_tdata[0];
            axis_in_tlast  = (i == n - 1);
            axis_in_tvalid = 1'b1;
            cyc = 0;
            do begin
                @(negedge aclk);
                acc = axis_in_tready;
                @(posedge aclk);
                #1;
                cyc++;
            end while (!acc && cyc < 2000);
            if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
            axis_in_tvalid = 1'b0;
            axis_in_tlast  = 1'b0;
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // Literal expectation for the logged packet: data from lit_d, tlast only on the final beat.
    task automatic check_log(input string nm);
        chk({nm, "_len"}, out_log.size(), lit_d.size());
        for (int i = 0; i < lit_d.size() && i < out_log.size(); i++) begin
            chk({nm, "_dat"}, {24'd0, out_log[i].d}, lit_d[i]);
            chk({nm, "_last"}, {31'd0, out_log[i].l}, (i == lit_d.size() - 1) ? 32'd1 : 32'd0);
        end
        out_log.delete();
    endtask

    int sizes[7] = '{16, 1, 1, 2, 3, 1, 20};
    int nlast;

    initial begin
        // Reset: outputs quiet even with an active source and ready sink.
        axis_in_tvalid  = 1'b1;
        axis_in_tdata   = 8'hAA;
        axis_in_tlast   = 1'b1;
        axis_in_tuser   = 1'b1;
        axis_out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_out_vld", {31'd0, axis_out_tvalid}, 32'd0);
        chk("rst_in_rdy", {31'd0, axis_in_tready}, 32'd0);
        chk("rst_out_dat", {24'd0, axis_out_tdata}, 32'd0);
        chk("rst_out_last", {31'd0, axis_out_tlast}, 32'd0);
        chk("rst_out_user", {31'd0, axis_out_tuser}, 32'd0);
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Long packet truncated, short packets padded, exact packet untouched.
        length = 32'd5;
        out_log.delete();
        send_pkt(16, 1); drain();
        lit_d = '{1, 2, 3, 4, 5}; check_log("t1_trunc");
        send_pkt(1, 1); drain();
        lit_d = '{1, 0, 0, 0, 0}; check_log("t2_pad1");
        send_pkt(2, 1); drain();
        lit_d = '{1, 2, 0, 0, 0}; check_log("t3_pad2");
        send_pkt(3, 1); drain();
        lit_d = '{1, 2, 3, 0, 0}; check_log("t3_pad3");
        send_pkt(5, 1); drain();
        lit_d = '{1, 2, 3, 4, 5}; check_log("t3_exact");

        // Back-to-back mixed sizes under random backpressure and gaps.
        rnd_rdy = 1'b1;
        gap_en  = 1'b1;
        for (int k = 0; k < 7; k++) send_pkt(sizes[k], k * 32 + 1);
        drain();
        chk("t4_beats", out_log.size(), 32'd35);
        nlast = 0;
        foreach (out_log[i]) if (out_log[i].l) nlast++;
        chk("t4_pkts", nlast, 32'd7);
        out_log.delete();
        rnd_rdy = 1'b0;
        gap_en  = 1'b0;
        @(posedge aclk);
        #2;
        axis_out_tready = 1'b1;

        // Transparent mode and single-beat length.
        length = 32'd0;
        send_pkt(3, 1); drain();
        lit_d = '{1, 2, 3}; check_log("t5_len0");
        length = 32'd1;
        send_pkt(3, 1); drain();
        lit_d = '{1}; check_log("t5_len1_long");
        send_pkt(1, 9); drain();
        lit_d = '{9}; check_log("t5_len1_single");

        // Clock enable low forces handshakes off.
        aclken = 1'b0;
        axis_in_tvalid = 1'b1;
        #1;
        chk("clken_out_vld", {31'd0, axis_out_tvalid}, 32'd0);
        chk("clken_in_rdy", {31'd0, axis_in_tready}, 32'd0);
        axis_in_tvalid = 1'b0;
        aclken = 1'b1;
        @(posedge aclk);
        #1;

        // Reset while padding abandons the packet; next packet starts clean.
        length = 32'd5;
        send_pkt(1, 7);
        axis_out_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("t6_pad_stalled_vld", {31'd0, axis_out_tvalid}, 32'd1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_vld", {31'd0, axis_out_tvalid}, 32'd0);
        chk("t6_rst_dat", {24'd0, axis_out_tdata}, 32'd0);
        exp_q.delete();
        out_log.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        axis_out_tready = 1'b1;
        send_pkt(2, 40); drain();
        lit_d = '{40, 41, 0, 0, 0}; check_log("t6_after_rst");

        repeat (3) @(posedge aclk);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
